led_matrix_scanner: RTL

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

---
 rtl/led_scan_pkg.sv | 19 +
 rtl/led_scan_regs.sv | 87 ++++++++
 rtl/led_matrix_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared constants for the LED matrix scanner.
// Register addresses, CTRL bit positions and scan FSM states.
package led_scan_pkg;

    localparam logic [3:0] A_CTRL   = 4'd8;
    localparam logic [3:0] A_DIV    = 4'd9;
    localparam logic [3:0] A_STATUS = 4'd10;

    localparam int C_EN    = 0;
    localparam int C_BLANK = 1;
    localparam int C_SWAP  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GUARD
    } scan_state_t;

endpackage

// File: rtl/led_scan_regs.sv
// Avalon-MM register file for the LED scanner.
// Holds BACK/FRONT frame buffers, CTRL, DIVIDER and swap handshake.
module led_scan_regs
    import led_scan_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd49999
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    input  logic [2:0]      cur_row,
    input  logic [7:0]      frame_cnt,
    input  logic            swap_evt,
    output logic            en_nxt,
    output logic            blank_nxt,
    output logic [15:0]     divider,
    output logic [7:0][7:0] front_nxt
);

    logic [7:0][7:0] back;
    logic [7:0][7:0] front;
    logic            en;
    logic            blank;
    logic            swap_pending;
    logic            wr;
    logic            wr_ctrl;
    logic            swap_now;
    logic            wd_unused;

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == A_CTRL);
    assign swap_now  = swap_evt && swap_pending;
    assign en_nxt    = wr_ctrl ? writedata[C_EN] : en;
    assign blank_nxt = wr_ctrl ? writedata[C_BLANK] : blank;
    assign wd_unused = ^writedata[31:16];

    // Next FRONT is exposed so the scanner shows swapped data on the wrap clock.
    always_comb begin
        front_nxt = front;
        if (swap_now) front_nxt = back;
    end

    always_comb begin
        readdata = '0;
        unique case (1'b1)
            !address[3]:
                readdata = {24'b0, back[address[2:0]]};
            address == A_CTRL:
                readdata = {29'b0, swap_pending, blank, en};
            address == A_DIV:
                readdata = {16'b0, divider};
            address == A_STATUS:
                readdata = {16'b0, frame_cnt, 4'b0, swap_pending, cur_row};
            default:
                readdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            back         <= '0;
            front        <= '0;
            en           <= 1'b0;
            blank        <= 1'b0;
            swap_pending <= 1'b0;
            divider      <= DIV_RESET;
        end else begin
            front <= front_nxt;
            en    <= en_nxt;
            blank <= blank_nxt;
            if (wr && !address[3])
                back[address[2:0]] <= writedata[7:0];
            if (wr && (address == A_DIV))
                divider <= writedata[15:0];
            // A new request on the swap clock survives for the next wrap.
            if (wr_ctrl && writedata[C_SWAP])
                swap_pending <= 1'b1;
            else if (swap_now)
                swap_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// 8x8 LED matrix row scanner with double-buffered frame memory.
// Scan FSM: ACTIVE dwell of DIVIDER+1 clocks, then GUARD blanking.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int          GUARD_CYCLES = 4,
    parameter logic [15:0] DIV_RESET    = 16'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done
);

    scan_state_t     state;
    scan_state_t     state_nxt;
    logic [2:0]      row;
    logic [2:0]      row_nxt;
    logic [15:0]     cnt;
    logic [15:0]     cnt_nxt;
    logic [7:0]      frame_cnt;
    logic            wrap;
    logic            swap_evt;
    logic            en_nxt;
    logic            blank_nxt;
    logic [15:0]     divider;
    logic [7:0][7:0] front_nxt;

    assign swap_evt = wrap || (state == S_IDLE);

    led_scan_regs #(
        .DIV_RESET (DIV_RESET)
    ) u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .cur_row    (row),
        .frame_cnt  (frame_cnt),
        .swap_evt   (swap_evt),
        .en_nxt     (en_nxt),
        .blank_nxt  (blank_nxt),
        .divider    (divider),
        .front_nxt  (front_nxt)
    );

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        if (!en_nxt) begin
            state_nxt = S_IDLE;
            row_nxt   = 3'd0;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_nxt = S_ACTIVE;
                    row_nxt   = 3'd0;
                    cnt_nxt   = divider;
                end
                S_ACTIVE: begin
                    if (cnt == '0) begin
                        state_nxt = S_GUARD;
                        cnt_nxt   = 16'(GUARD_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                S_GUARD: begin
                    if (cnt == '0) begin
                        state_nxt = S_ACTIVE;
                        cnt_nxt   = divider;
                        row_nxt   = row + 3'd1;
                        wrap      = (row == 3'd7);
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    row_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            row        <= 3'd0;
            cnt        <= '0;
            frame_cnt  <= 8'd0;
            row_sel    <= 8'd0;
            col_data   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            cnt        <= cnt_nxt;
            frame_done <= wrap;
            if (wrap) frame_cnt <= frame_cnt + 8'd1;
            // Outputs follow the next state so they line up with it.
            if (state_nxt == S_ACTIVE) begin
                row_sel  <= 8'h01 << row_nxt;
                col_data <= blank_nxt ? 8'd0 : front_nxt[row_nxt];
            end else begin
                row_sel  <= 8'd0;
                col_data <= 8'd0;
            end
        end
    end

endmodule
